// File: rtl/accum_xcel_pkg.sv
// ---------------------------------------------------------------------------
// accum_xcel_pkg
// Shared constants and types for the accumulator accelerator memory adapter.
//   ADDR_NBITS    : default request address width
//   DATA_NBITS    : default load data width
//   DEFAULT_DEPTH : default response FIFO depth / outstanding-load limit
//   credit_t      : credit counter type sized for DEFAULT_DEPTH (0..depth)
//   credit_width  : counter width for an arbitrary depth
// ---------------------------------------------------------------------------
package accum_xcel_pkg;

    localparam int ADDR_NBITS    = 32;
    localparam int DATA_NBITS    = 32;
    localparam int DEFAULT_DEPTH = 4;

    // One extra bit so the counter can hold the value "depth" itself.
    localparam int CREDIT_NBITS  = $clog2(DEFAULT_DEPTH) + 1;

    typedef logic [CREDIT_NBITS-1:0] credit_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/accum_xcel_mem_adapter_if.sv
// ---------------------------------------------------------------------------
// accum_xcel_mem_adapter_if
// Bundles the four valid/ready channels around the memory adapter.
//   xreq_*    : accelerator load requests into the adapter
//   xresp_*   : buffered load data back to the accelerator
//   memreq_*  : requests forwarded to the memory port
//   memresp_* : memory responses (no back-pressure)
// Modports:
//   slave  : the adapter's view
//   master : the surrounding system's view (accelerator + memory)
// ---------------------------------------------------------------------------
interface accum_xcel_mem_adapter_if
    import accum_xcel_pkg::*;
#(
    parameter int p_addr_nbits = ADDR_NBITS,
    parameter int p_data_nbits = DATA_NBITS
);

    logic                    xreq_val;
    logic                    xreq_rdy;
    logic [p_addr_nbits-1:0] xreq_addr;

    logic                    xresp_val;
    logic                    xresp_rdy;
    logic [p_data_nbits-1:0] xresp_data;

    logic                    memreq_val;
    logic                    memreq_rdy;
    logic [p_addr_nbits-1:0] memreq_addr;

    logic                    memresp_val;
    logic [p_data_nbits-1:0] memresp_data;

    modport slave (
        input  xreq_val, xreq_addr, xresp_rdy, memreq_rdy, memresp_val, memresp_data,
        output xreq_rdy, xresp_val, xresp_data, memreq_val, memreq_addr
    );

    modport master (
        output xreq_val, xreq_addr, xresp_rdy, memreq_rdy, memresp_val, memresp_data,
        input  xreq_rdy, xresp_val, xresp_data, memreq_val, memreq_addr
    );

endinterface

// File: rtl/accum_xcel_reg.sv
// ---------------------------------------------------------------------------
// accum_xcel_reg
// Plain D register with asynchronous active-low reset to a parameter value.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active low
//   i_d   : next value
//   o_q   : registered value
// ---------------------------------------------------------------------------
module accum_xcel_reg #(
    parameter int                 p_nbits     = 1,
    parameter logic [p_nbits-1:0] p_reset_val = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [p_nbits-1:0] i_d,
    output logic [p_nbits-1:0] o_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) o_q <= p_reset_val;
        else      o_q <= i_d;
    end

endmodule

// File: rtl/accum_xcel_resp_fifo.sv
// ---------------------------------------------------------------------------
// accum_xcel_resp_fifo
// Synchronous FIFO holding memory responses until the accelerator takes them.
//   clk         : rising-edge clock
//   rst         : asynchronous reset, active low
//   i_enq_val   : write i_enq_data at the tail (ignored when full)
//   i_enq_data  : data to enqueue
//   i_deq_rdy   : pop the head (ignored when empty)
//   o_deq_data  : current head entry
//   o_full      : all p_depth entries occupied
//   o_empty     : no entries
//   o_occupancy : number of entries, 0..p_depth
// ---------------------------------------------------------------------------
module accum_xcel_resp_fifo #(
    parameter int p_depth = 4,
    parameter int p_width = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_enq_val,
    input  logic [p_width-1:0]         i_enq_data,
    input  logic                       i_deq_rdy,
    output logic [p_width-1:0]         o_deq_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(p_depth):0]   o_occupancy
);

    localparam int PW = $clog2(p_depth);
    localparam int OW = PW + 1;

    logic [p_width-1:0] r_mem [p_depth];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [OW-1:0]      r_occ;
    logic               w_enq;
    logic               w_deq;

    assign o_full      = (r_occ == OW'(p_depth));
    assign o_empty     = (r_occ == '0);
    assign o_occupancy = r_occ;
    assign o_deq_data  = r_mem[r_rd_ptr];

    assign w_enq = i_enq_val & ~o_full;
    assign w_deq = i_deq_rdy & ~o_empty;

    // Storage needs no reset; empty/occupancy decide what is visible.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= i_enq_data;
    end

    // Pointers wrap naturally because p_depth is a power of two; the
    // separate occupancy counter disambiguates full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_enq && !w_deq)      r_occ <= r_occ + OW'(1);
            else if (w_deq && !w_enq) r_occ <= r_occ - OW'(1);
        end
    end

endmodule

// File: rtl/accum_xcel_mem_adapter.sv
// ---------------------------------------------------------------------------
// accum_xcel_mem_adapter
// Memory-side stage of the accumulator accelerator. Forwards load requests to
// memory, buffers responses in order, and limits outstanding loads with a
// credit counter so a response always has a FIFO slot waiting for it.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : request/response channels (slave view of the adapter interface)
//   busy : at least one load outstanding or buffered
//   err  : sticky flag for unexpected memory responses, cleared by reset
// ---------------------------------------------------------------------------
module accum_xcel_mem_adapter
    import accum_xcel_pkg::*;
#(
    parameter int p_depth      = DEFAULT_DEPTH,
    parameter int p_addr_nbits = ADDR_NBITS,
    parameter int p_data_nbits = DATA_NBITS
) (
    input  logic                     clk,
    input  logic                     rst,
    accum_xcel_mem_adapter_if.slave  bus,
    output logic                     busy,
    output logic                     err
);

    localparam int CW = credit_width(p_depth);
    localparam logic [CW-1:0] DEPTH_C = CW'(p_depth);

    logic [CW-1:0]           r_credit;
    logic [CW-1:0]           w_credit_next;
    logic [CW-1:0]           w_fifo_occ;
    logic [CW-1:0]           w_inflight;
    logic                    r_err;
    logic                    w_err_next;
    logic                    w_has_credit;
    logic                    w_req_fire;
    logic                    w_deq_fire;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_resp_err;
    logic                    w_enq_val;
    logic [p_addr_nbits-1:0] w_addr;
    logic [p_data_nbits-1:0] w_head_data;

    // Credit is judged on the registered count only, so a dequeue frees a
    // slot for requests one cycle later and no rdy->val loop exists.
    assign w_has_credit = (r_credit < DEPTH_C);

    // Reset also gates the request handshake so nothing can fire while
    // the adapter is held in reset.
    assign bus.xreq_rdy   = rst & bus.memreq_rdy & w_has_credit;
    assign bus.memreq_val = rst & bus.xreq_val & w_has_credit;
    assign w_addr          = bus.xreq_addr;
    assign bus.memreq_addr = w_addr;

    assign w_req_fire = bus.xreq_val & bus.xreq_rdy;

    assign bus.xresp_val  = ~w_fifo_empty;
    assign bus.xresp_data = w_head_data;
    assign w_deq_fire     = bus.xresp_val & bus.xresp_rdy;

    // Loads still inside memory; a response with none in flight, or with
    // nowhere to go, is a protocol violation and is dropped.
    assign w_inflight = r_credit - w_fifo_occ;
    assign w_resp_err = bus.memresp_val & ((w_inflight == '0) | w_fifo_full);
    assign w_enq_val  = bus.memresp_val & ~w_resp_err;

    always_comb begin
        w_credit_next = r_credit;
        if (w_req_fire && !w_deq_fire)      w_credit_next = r_credit + CW'(1);
        else if (w_deq_fire && !w_req_fire) w_credit_next = r_credit - CW'(1);
    end

    assign w_err_next = r_err | w_resp_err;

    accum_xcel_reg #(.p_nbits(CW), .p_reset_val('0)) u_credit_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_credit_next),
        .o_q (r_credit)
    );

    accum_xcel_reg #(.p_nbits(1), .p_reset_val(1'b0)) u_err_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_err_next),
        .o_q (r_err)
    );

    accum_xcel_resp_fifo #(.p_depth(p_depth), .p_width(p_data_nbits)) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_enq_val   (w_enq_val),
        .i_enq_data  (bus.memresp_data),
        .i_deq_rdy   (bus.xresp_rdy),
        .o_deq_data  (w_head_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_occupancy (w_fifo_occ)
    );

    assign busy = (r_credit != '0);
    assign err  = r_err;

endmodule

// File: tb/tb_accum_xcel_mem_adapter.sv
// ---------------------------------------------------------------------------
// tb_accum_xcel_mem_adapter
// Directed bench for the accumulator memory adapter (depth 4, 32-bit data).
// ---------------------------------------------------------------------------
module tb_accum_xcel_mem_adapter;

    logic clk;
    logic rst;
    logic busy;
    logic err;

    int checkCount;
    int passCount;

    accum_xcel_mem_adapter_if #(.p_addr_nbits(32), .p_data_nbits(32)) bus ();

    accum_xcel_mem_adapter #(.p_depth(4), .p_addr_nbits(32), .p_data_nbits(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                      tag, observed, expected, $time);
    endtask

    // Drive all inputs just after a falling edge, then settle for 1 ns.
    task automatic applyStimulus(input logic xv, input logic [31:0] xa,
                                 input logic rr, input logic mrdy,
                                 input logic mv, input logic [31:0] md);
        bus.xreq_val     = xv;
        bus.xreq_addr    = xa;
        bus.xresp_rdy    = rr;
        bus.memreq_rdy   = mrdy;
        bus.memresp_val  = mv;
        bus.memresp_data = md;
        #1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b0;
        idle();
        nextCycle();
        nextCycle();
        rst = 1'b1;
    endtask

    task automatic issueRequests(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, base + 32'(i * 4), 1'b0, 1'b1, 1'b0, 32'h0);
            nextCycle();
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;

        // Reset state: request pending and memory ready, yet nothing may pass.
        rst = 1'b0;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_xreq_rdy",   32'(bus.xreq_rdy),   32'h0);
        checkOutput("rst_memreq_val", 32'(bus.memreq_val), 32'h0);
        checkOutput("rst_xresp_val",  32'(bus.xresp_val),  32'h0);
        checkOutput("rst_busy",       32'(busy),           32'h0);
        checkOutput("rst_err",        32'(err),            32'h0);
        idle();
        nextCycle();
        nextCycle();
        rst = 1'b1;

        $display("[TB] single load");
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_memreq_val",  32'(bus.memreq_val), 32'h1);
        checkOutput("t1_memreq_addr", bus.memreq_addr,     32'h0000_0100);
        checkOutput("t1_xreq_rdy",    32'(bus.xreq_rdy),   32'h1);
        nextCycle();
        idle();
        checkOutput("t1_busy_after_req", 32'(busy),          32'h1);
        checkOutput("t1_no_early_resp",  32'(bus.xresp_val), 32'h0);
        nextCycle();
        idle();
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        checkOutput("t1_no_bypass", 32'(bus.xresp_val), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_xresp_val",  32'(bus.xresp_val), 32'h1);
        checkOutput("t1_xresp_data", bus.xresp_data,     32'hDEAD_BEEF);
        checkOutput("t1_busy_held",  32'(busy),          32'h1);
        nextCycle();
        idle();
        checkOutput("t1_xresp_done", 32'(bus.xresp_val), 32'h0);
        checkOutput("t1_busy_fall",  32'(busy),          32'h0);
        checkOutput("t1_err",        32'(err),           32'h0);

        $display("[TB] credit saturation");
        doReset();
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_rdy_needs_memrdy", 32'(bus.xreq_rdy),   32'h0);
        checkOutput("t2_val_no_memrdy",    32'(bus.memreq_val), 32'h1);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("t2_rdy_credit", 32'(bus.xreq_rdy), 32'h1);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_rdy_full",    32'(bus.xreq_rdy),   32'h0);
        checkOutput("t2_memval_full", 32'(bus.memreq_val), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b1, 1'b1, 32'h0000_00A0);
        nextCycle();
        applyStimulus(1'b1, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_resp_val",        32'(bus.xresp_val), 32'h1);
        checkOutput("t2_resp_data",       bus.xresp_data,     32'h0000_00A0);
        checkOutput("t2_rdy_same_cycle",  32'(bus.xreq_rdy),  32'h0);
        nextCycle();
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_rdy_next_cycle", 32'(bus.xreq_rdy), 32'h1);

        $display("[TB] back-pressure");
        doReset();
        issueRequests(4, 32'h3000);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'(k));
            nextCycle();
        end
        idle();
        checkOutput("t3_no_err_full", 32'(err),           32'h0);
        checkOutput("t3_head_val",    32'(bus.xresp_val), 32'h1);
        checkOutput("t3_head_data",   bus.xresp_data,     32'h1);
        checkOutput("t3_rdy_full",    32'(bus.xreq_rdy),  32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h5);
        nextCycle();
        idle();
        checkOutput("t3_err_overflow", 32'(err), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("t3_drain_val",  32'(bus.xresp_val), 32'h1);
            checkOutput("t3_drain_data", bus.xresp_data,     32'(k));
            nextCycle();
        end
        idle();
        checkOutput("t3_drained", 32'(bus.xresp_val), 32'h0);
        checkOutput("t3_idle",    32'(busy),          32'h0);

        $display("[TB] simultaneous request and dequeue");
        doReset();
        issueRequests(2, 32'h4000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h77);
        nextCycle();
        applyStimulus(1'b1, 32'h4100, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_rdy",       32'(bus.xreq_rdy),  32'h1);
        checkOutput("t4_resp_val",  32'(bus.xresp_val), 32'h1);
        checkOutput("t4_resp_data", bus.xresp_data,     32'h77);
        nextCycle();
        applyStimulus(1'b1, 32'h4104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_busy",      32'(busy),          32'h1);
        checkOutput("t4_fifo_empty", 32'(bus.xresp_val), 32'h0);
        checkOutput("t4_rdy_c2",    32'(bus.xreq_rdy),  32'h1);
        nextCycle();
        applyStimulus(1'b1, 32'h4108, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_rdy_c3", 32'(bus.xreq_rdy), 32'h1);
        nextCycle();
        applyStimulus(1'b1, 32'h410C, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_rdy_c4", 32'(bus.xreq_rdy), 32'h0);

        $display("[TB] spurious response");
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h55);
        checkOutput("t5_err_before", 32'(err), 32'h0);
        nextCycle();
        idle();
        checkOutput("t5_err_set",    32'(err),           32'h1);
        checkOutput("t5_no_resp",    32'(bus.xresp_val), 32'h0);
        checkOutput("t5_not_busy",   32'(busy),          32'h0);
        nextCycle();
        nextCycle();
        checkOutput("t5_err_sticky", 32'(err), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("t5_err_cleared", 32'(err), 32'h0);

        $display("[TB] async reset mid-flight");
        doReset();
        issueRequests(3, 32'h5000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h99);
        nextCycle();
        applyStimulus(1'b1, 32'h5100, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_pre_resp_val",   32'(bus.xresp_val),  32'h1);
        checkOutput("t6_pre_memreq_val", 32'(bus.memreq_val), 32'h1);
        checkOutput("t6_pre_busy",       32'(busy),           32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_resp_val",   32'(bus.xresp_val),  32'h0);
        checkOutput("t6_rst_memreq_val", 32'(bus.memreq_val), 32'h0);
        checkOutput("t6_rst_busy",       32'(busy),           32'h0);
        checkOutput("t6_rst_err",        32'(err),            32'h0);
        nextCycle();
        idle();
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_new_memreq_val",  32'(bus.memreq_val), 32'h1);
        checkOutput("t6_new_memreq_addr", bus.memreq_addr,     32'h0000_0200);
        checkOutput("t6_new_xreq_rdy",    32'(bus.xreq_rdy),   32'h1);
        nextCycle();
        idle();
        checkOutput("t6_new_busy", 32'(busy), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_new_resp_val",  32'(bus.xresp_val), 32'h1);
        checkOutput("t6_new_resp_data", bus.xresp_data,     32'h1234);
        checkOutput("t6_new_err",       32'(err),           32'h0);
        nextCycle();
        idle();
        checkOutput("t6_new_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
